// File: rtl/motor_sched_pkg.sv
// motor_sched_pkg: shared types and default constants for the motor scheduler.
package motor_sched_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_MV_UP = 5'b00010,
      ST_MV_DN = 5'b00100,
      ST_DEAD  = 5'b01000,
      ST_FAULT = 5'b10000
   } state_t;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

   localparam int DEAD_CYC_DEF = 8;
   localparam int TMO_CYC_DEF  = 50000;

endpackage

// File: rtl/motor_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible requester
// at or after the pointer. The pointer register lives in the parent.
module rr_arbiter
   import motor_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  elig_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  pick_o,
   output logic             vld_o
);

   // scan from the pointer, wrapping, and keep the first hit
   always_comb begin
      int idx;
      pick_o = '0;
      vld_o  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_i) + k) % NREQ;
         if (!vld_o && elig_i[idx]) begin
            pick_o[idx] = 1'b1;
            vld_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/motor_sched.sv
// motor_sched: round-robin scheduler for a shared up/down motor with limit
// switches, post-move dead-time and latched fault.
// Optional build macro: MOTOR_SCHED_WDOG_EN adds the move watchdog.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | waiting for an eligible request
//   ST_MV_UP | driving up until up_max
//   ST_MV_DN | driving down until dn_max
//   ST_DEAD  | drives off for DEAD_CYC cycles
//   ST_FAULT | drives off until fault_clr
module motor_sched
   import motor_sched_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DEAD_CYC = DEAD_CYC_DEF,
   parameter int TMO_W    = 16,
   parameter int TMO_CYC  = TMO_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_up,
   input  logic [NREQ-1:0] req_dn,
   input  logic            up_max,
   input  logic            dn_max,
   input  logic            fault_clr,
   output logic [NREQ-1:0] grant,
   output logic            up_M,
   output logic            dn_M,
   output logic            busy,
   output logic            fault
);

   localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("NREQ must be in 2..8");
   end
   if (DEAD_CYC < 1) begin : g_bad_dead
      $error("DEAD_CYC must be at least 1");
   end
   if (TMO_CYC < 1 || TMO_W > 30 || TMO_CYC >= (1 << TMO_W)) begin : g_bad_tmo
      $error("TMO_CYC must fit in TMO_W bits");
   end

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [DEAD_W-1:0] dead_q, dead_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   elig, pick;
   logic              pick_vld;
   logic [PTR_W-1:0]  pick_idx;
   dir_t              pick_dir;
   logic              both_lim;
   logic              tmo;

   assign both_lim = up_max & dn_max;

   // a requester qualifies with exactly one direction and its target limit clear
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = (req_up[i] ^ req_dn[i]) & (req_up[i] ? ~up_max : ~dn_max);
      end
   end

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .pick_o (pick),
      .vld_o  (pick_vld)
   );

   // index and direction of the arbiter's pick
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = PTR_W'(i);
      end
      pick_dir = ((pick & req_up) != '0) ? DIR_UP : DIR_DN;
   end

`ifdef MOTOR_SCHED_WDOG_EN
   logic [TMO_W-1:0] wdog_q, wdog_d;

   // move-time counter: zero outside a move, saturating inside one
   always_comb begin
      tmo = (wdog_q >= TMO_W'(TMO_CYC - 1));
      if (state_q == ST_MV_UP || state_q == ST_MV_DN) begin
         wdog_d = (&wdog_q) ? wdog_q : wdog_q + TMO_W'(1);
      end else begin
         wdog_d = '0;
      end
   end

   // watchdog register
   always_ff @(posedge clk) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end
`else
   assign tmo = 1'b0;
`endif

   // state, pointer, dead-time and grant registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         dead_q  <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         dead_q  <= dead_d;
         grant_q <= grant_d;
      end
   end

   // next state: both-limits fault beats limit reached beats timeout
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      dead_d  = dead_q;
      grant_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (both_lim) begin
               state_d = ST_FAULT;
            end else if (pick_vld) begin
               state_d = (pick_dir == DIR_UP) ? ST_MV_UP : ST_MV_DN;
               grant_d = pick;
               ptr_d   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end
         end
         ST_MV_UP: begin
            if (both_lim)    state_d = ST_FAULT;
            else if (up_max) state_d = ST_DEAD;
            else if (tmo)    state_d = ST_FAULT;
         end
         ST_MV_DN: begin
            if (both_lim)    state_d = ST_FAULT;
            else if (dn_max) state_d = ST_DEAD;
            else if (tmo)    state_d = ST_FAULT;
         end
         ST_DEAD: begin
            if (both_lim)          state_d = ST_FAULT;
            else if (dead_q == '0) state_d = ST_IDLE;
            else                   dead_d  = dead_q - DEAD_W'(1);
         end
         ST_FAULT: begin
            if (fault_clr) state_d = ST_DEAD;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_DEAD && state_q != ST_DEAD) begin
         dead_d = DEAD_W'(DEAD_CYC - 1);
      end
   end

   // Moore outputs decoded straight from the one-hot state register
   always_comb begin
      grant = grant_q;
      up_M  = (state_q == ST_MV_UP);
      dn_M  = (state_q == ST_MV_DN);
      busy  = (state_q != ST_IDLE);
      fault = (state_q == ST_FAULT);
   end

endmodule

// File: tb/tb_motor_sched.sv
// tb_motor_sched: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the scheduler.
module tb_motor_sched;

   localparam int NREQ     = 4;
   localparam int DEAD_CYC = 8;
   localparam int TMO_W    = 16;
   localparam int TMO_CYC  = 100;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req_up = '0;
   logic [NREQ-1:0] req_dn = '0;
   logic            up_max = 1'b0;
   logic            dn_max = 1'b0;
   logic            fault_clr = 1'b0;
   logic [NREQ-1:0] grant;
   logic            up_M, dn_M, busy, fault;

   motor_sched #(
      .NREQ     (NREQ),
      .DEAD_CYC (DEAD_CYC),
      .TMO_W    (TMO_W),
      .TMO_CYC  (TMO_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_up    (req_up),
      .req_dn    (req_dn),
      .up_max    (up_max),
      .dn_max    (dn_max),
      .fault_clr (fault_clr),
      .grant     (grant),
      .up_M      (up_M),
      .dn_M      (dn_M),
      .busy      (busy),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // model: m_mv 0=stopped 1=up 2=down; m_dead = dead cycles still to run
   int              m_mv = 0, m_dead = 0, m_ptr = 0, m_age = 0;
   bit              m_fault = 1'b0;
   logic [NREQ-1:0] m_grant = '0;

   function automatic bit elig(input int i);
      if (req_up[i] == req_dn[i]) return 1'b0;
      return req_up[i] ? !up_max : !dn_max;
   endfunction

   task automatic model_step();
      bit found;
      int idx;
      m_grant = '0;
      if (rst) begin
         m_mv = 0; m_dead = 0; m_fault = 1'b0; m_ptr = 0; m_age = 0;
      end else if (!m_fault && up_max && dn_max) begin
         m_fault = 1'b1; m_mv = 0; m_dead = 0;
      end else if (m_fault) begin
         if (fault_clr) begin
            m_fault = 1'b0; m_dead = DEAD_CYC;
         end
      end else if (m_mv != 0) begin
         if ((m_mv == 1 && up_max) || (m_mv == 2 && dn_max)) begin
            m_mv = 0; m_dead = DEAD_CYC;
         end
`ifdef MOTOR_SCHED_WDOG_EN
         else if (m_age >= TMO_CYC - 1) begin
            m_mv = 0; m_fault = 1'b1;
         end
`endif
         else m_age++;
      end else if (m_dead > 0) begin
         m_dead--;
      end else begin
         found = 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (!found && elig(idx)) begin
               found = 1'b1;
               m_grant[idx] = 1'b1;
               m_mv  = req_up[idx] ? 1 : 2;
               m_ptr = (idx + 1) % NREQ;
               m_age = 0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("grant", grant, m_grant);
      check("up_M", up_M, m_mv == 1);
      check("dn_M", dn_M, m_mv == 2);
      check("busy", busy, (m_mv != 0) || (m_dead > 0) || m_fault);
      check("fault", fault, m_fault);
      check("drive_excl", up_M & dn_M, 1'b0);
   endtask

   task automatic do_reset();
      req_up = '0; req_dn = '0; up_max = 1'b0; dn_max = 1'b0; fault_clr = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int n, ngr;
      int rr_exp[4] = '{0, 1, 3, 0};

      // reset state
      do_reset();
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);

      // single requester up, stop, dead-time length
      dn_max = 1'b1; req_up = 4'b0100;
      step();
      check("sr_grant", grant, 4'b0100);
      check("sr_up", up_M, 1);
      step();
      check("sr_grant_pulse", grant, 0);
      dn_max = 1'b0;
      repeat (18) step();
      up_max = 1'b1;
      step();
      check("sr_stop", up_M, 0);
      n = 0;
      while (busy && n < 50) begin step(); n++; end
      check("sr_dead_len", n, DEAD_CYC);
      req_up = '0; up_max = 1'b0;

      // round-robin order with requesters 0,1,3
      do_reset();
      req_dn = 4'b1011;
      for (int j = 0; j < 4; j++) begin
         n = 0;
         while (grant == '0 && n < 40) begin step(); n++; end
         check("rr_order", oh_idx(grant), rr_exp[j]);
         repeat (3) step();
         dn_max = 1'b1;
         step();
         dn_max = 1'b0;
      end

      // ineligible requesters are skipped
      do_reset();
      req_up = 4'b0011; req_dn = 4'b0101; up_max = 1'b1;
      ngr = 0;
      for (int j = 0; j < 30; j++) begin
         step();
         if (grant != '0) begin
            ngr++;
            check("skip_grant", grant, 4'b0100);
         end
         check("skip_noup", up_M, 0);
      end
      check("skip_ngrants", ngr, 1);

`ifdef MOTOR_SCHED_WDOG_EN
      // watchdog timeout, then clear
      do_reset();
      req_up = 4'b0001;
      step();
      req_up = '0;
      n = 0;
      while (!fault && n < 300) begin step(); n++; end
      check("wd_latency", n, TMO_CYC);
      check("wd_drive_off", up_M, 0);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      check("wd_clr", fault, 0);
      n = 0;
      while (busy && n < 50) begin step(); n++; end
      check("wd_dead_len", n, DEAD_CYC);

      // limit and timeout in the same cycle resolve to DEAD
      do_reset();
      req_up = 4'b0001;
      step();
      req_up = '0;
      repeat (TMO_CYC - 1) step();
      up_max = 1'b1;
      step();
      check("lim_tmo_fault", fault, 0);
      check("lim_tmo_busy", busy, 1);
      up_max = 1'b0;
`else
      // without the watchdog a move runs until its limit
      do_reset();
      req_up = 4'b0001;
      step();
      req_up = '0;
      repeat (TMO_CYC + 50) step();
      check("nowd_moving", up_M, 1);
      check("nowd_nofault", fault, 0);
      up_max = 1'b1;
      step();
      up_max = 1'b0;
`endif

      // both limits during a down move
      do_reset();
      req_dn = 4'b0010;
      step();
      req_dn = '0;
      repeat (5) step();
      up_max = 1'b1; dn_max = 1'b1;
      step();
      check("sens_fault", fault, 1);
      check("sens_dn_off", dn_M, 0);
      up_max = 1'b0; dn_max = 1'b0; fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;

      // reset mid-move restarts the pointer
      do_reset();
      req_up = 4'b0010;
      step();
      check("rm_first", grant, 4'b0010);
      req_up = 4'b0011;
      repeat (3) step();
      rst = 1'b1;
      step();
      check("rm_up_off", up_M, 0);
      check("rm_busy_off", busy, 0);
      rst = 1'b0;
      step();
      check("rm_grant0", grant, 4'b0001);

      // random traffic
      do_reset();
      for (int j = 0; j < 3000; j++) begin
         rst       = ($urandom_range(0, 299) == 0);
         req_up    = NREQ'($urandom);
         req_dn    = NREQ'($urandom);
         up_max    = ($urandom_range(0, 9) == 0);
         dn_max    = ($urandom_range(0, 9) == 0);
         fault_clr = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
